// File: rtl/lw_sha_regs_pkg.sv
// Register map, bit positions, control FSM states and register layouts for the
// lightweight SHA/HMAC bus-side control block.
package lw_sha_regs_pkg;

    localparam logic [11:0] ADDR_ID      = 12'h000;
    localparam logic [11:0] ADDR_CFG     = 12'h010;
    localparam logic [11:0] ADDR_CTL     = 12'h020;
    localparam logic [11:0] ADDR_STS     = 12'h030;
    localparam logic [11:0] ADDR_IE      = 12'h040;
    localparam logic [11:0] ADDR_FLVL    = 12'h050;
    localparam logic [11:0] ADDR_HASH_LO = 12'h100;
    localparam logic [11:0] ADDR_HASH_HI = 12'h13F;
    localparam logic [11:0] ADDR_DIN     = 12'h140;
    localparam logic [11:0] ADDR_KEY     = 12'h150;

    localparam int unsigned CFG_NEWKEY_BIT = 4;
    localparam int unsigned CFG_BSWAP_BIT  = 8;
    localparam int unsigned CFG_SRST_BIT   = 31;

    localparam int unsigned CTL_INIT_BIT  = 0;
    localparam int unsigned CTL_LAST_BIT  = 1;
    localparam int unsigned CTL_ABORT_BIT = 2;

    localparam int unsigned STS_AVL_BIT  = 0;
    localparam int unsigned STS_RDYD_BIT = 1;
    localparam int unsigned STS_RDYK_BIT = 2;
    localparam int unsigned STS_DERR_BIT = 3;
    localparam int unsigned STS_BUSY_BIT = 4;
    localparam int unsigned STS_FID_BIT  = 5;
    localparam int unsigned STS_OVF_BIT  = 6;
    localparam int unsigned STS_W        = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_RUN,
        ST_DRAIN,
        ST_WAIT_DONE
    } ctrl_state_e;

    typedef struct packed {
        logic       srst;
        logic       bswap;
        logic       hmacnewkey;
        logic [3:0] opcode;
    } cfg_t;

    // Field order matches the STS/IE bit positions (ovf is bit 6, avl bit 0).
    typedef struct packed {
        logic ovf;
        logic fid;
        logic busy;
        logic derr;
        logic rdyk;
        logic rdyd;
        logic avl;
    } sts_t;

    typedef struct packed {
        logic ovf;
        logic fid;
        logic busy;
        logic derr;
        logic rdyk;
        logic rdyd;
        logic avl;
    } ie_t;

    localparam ie_t IE_RST = ie_t'(7'h02);

    function automatic logic [31:0] cfg_to_reg(input cfg_t c);
        return {c.srst, 22'b0, c.bswap, 3'b0, c.hmacnewkey, c.opcode};
    endfunction

endpackage

// File: rtl/lw_sha_word_fifo.sv
// Core-word FIFO feeding the hash core; flush clears occupancy, push+pop when
// full is accepted.
module lw_sha_word_fifo #(
    parameter int unsigned WORD_W     = 64,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          flush_i,
    input  logic                          push_i,
    input  logic [WORD_W-1:0]             data_i,
    input  logic                          pop_i,
    output logic [WORD_W-1:0]             data_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wptr_q, rptr_q;
    logic [LVL_W-1:0]  cnt_q;
    logic              push_ok, pop_ok;

    assign full_o  = (cnt_q == LVL_W'(FIFO_DEPTH));
    assign empty_o = (cnt_q == '0);
    assign level_o = cnt_q;
    assign data_o  = mem_q[rptr_q];
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wptr_q] <= data_i;
                wptr_q        <= wptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rptr_q <= rptr_q + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + LVL_W'(1);
                2'b01:   cnt_q <= cnt_q - LVL_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/lw_sha_fifo_interface_ctrl.sv
// Bus register/control block for the lightweight SHA/HMAC core: DIN FIFO, key
// packer, command FSM and digest capture. SHA_DIN_BYTE_SWAP_EN enables CFG.bswap.
module lw_sha_fifo_interface_ctrl
    import lw_sha_regs_pkg::*;
#(
    parameter int unsigned BUS_W      = 32,
    parameter int unsigned WORD_W     = 64,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [31:0] ID_VAL     = 32'h0
) (
    input  logic                  clk_i,
    input  logic                  resetn_i,
    input  logic                  wr_i,
    input  logic [11:0]           waddr_i,
    input  logic [BUS_W-1:0]      wdata_i,
    output logic                  wr_ack_o,
    input  logic                  rd_i,
    input  logic [11:0]           raddr_i,
    output logic [BUS_W-1:0]      rdata_o,
    output logic                  read_valid_o,
    output logic                  slv_error_o,
    output logic                  irq_o,
    output logic [WORD_W-1:0]     data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [WORD_W-1:0]     key_o,
    output logic                  key_valid_o,
    input  logic                  key_ready_i,
    output logic                  start_o,
    output logic                  last_o,
    output logic                  abort_o,
    output logic [3:0]            opcode_o,
    output logic                  new_key_o,
    input  logic                  core_ready_i,
    input  logic                  done_i,
    input  logic                  fault_inj_det_i,
    input  logic [8*WORD_W-1:0]   hash_i,
    output logic                  dma_wr_req_o,
    output logic                  dma_rd_req_o,
    output logic                  core_reset_o
);
    localparam int unsigned LVL_W       = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned NBYTES      = BUS_W / 8;
    localparam int unsigned BYTE_SH     = $clog2(NBYTES);
    localparam int unsigned HASH_CHUNKS = (8 * WORD_W) / BUS_W;

    ctrl_state_e state_q, state_d;
    cfg_t        cfg_q, cfg_d;
    ie_t         ie_q, ie_d;
    sts_t        sts_c;
    logic        avl_q, avl_d, derr_q, derr_d, ovf_q, ovf_d;
    logic        din_half_q, din_half_d, key_half_q, key_half_d;
    logic [31:0] din_hi_q, din_hi_d, key_hi_q, key_hi_d;
    logic [WORD_W-1:0] key_q, key_d;
    logic        key_valid_q, key_valid_d;
    logic [HASH_CHUNKS-1:0][BUS_W-1:0] hash_q, hash_d;
    logic        start_q, start_d, last_q, last_d, abort_q, abort_d;
    logic        avl_set, avl_clr;

    logic [BUS_W-1:0]  bus_word;
    logic              mode32, pack_mode;
    logic              cfg_wr, ctl_wr, sts_wr, ie_wr, din_wr, key_wr, abort_req, soft_rst;
    logic              din_drop, din_push, key_drop, key_ld;
    logic [WORD_W-1:0] din_word, key_word;
    logic              fifo_full, fifo_empty, fifo_pop;
    logic [LVL_W-1:0]  fifo_level;
    logic [5-BYTE_SH:0] hash_idx;

`ifdef SHA_DIN_BYTE_SWAP_EN
    function automatic logic [BUS_W-1:0] byte_rev(input logic [BUS_W-1:0] w);
        logic [BUS_W-1:0] r;
        r = '0;
        for (int b = 0; b < NBYTES; b++) begin
            r[8*b +: 8] = w[8*(NBYTES-1-b) +: 8];
        end
        return r;
    endfunction
    assign bus_word = cfg_q.bswap ? byte_rev(wdata_i) : wdata_i;
`else
    assign bus_word = wdata_i;
`endif

    // 32-bit algorithms (opcode[3:2]==0) use one bus write per zero-extended word.
    function automatic logic [WORD_W-1:0] form_word(input logic [31:0] hi,
                                                    input logic [BUS_W-1:0] w,
                                                    input logic pack, input logic m32);
        if (pack)     return WORD_W'({hi, w[31:0]});
        else if (m32) return WORD_W'(w[31:0]);
        else          return WORD_W'(w);
    endfunction

    assign mode32    = (WORD_W == 32) || (cfg_q.opcode[3:2] == 2'b00);
    assign pack_mode = (WORD_W == 64) && (BUS_W == 32) && !mode32;

    assign cfg_wr    = wr_i && (waddr_i == ADDR_CFG);
    assign ctl_wr    = wr_i && (waddr_i == ADDR_CTL);
    assign sts_wr    = wr_i && (waddr_i == ADDR_STS);
    assign ie_wr     = wr_i && (waddr_i == ADDR_IE);
    assign din_wr    = wr_i && (waddr_i == ADDR_DIN);
    assign key_wr    = wr_i && (waddr_i == ADDR_KEY);
    assign abort_req = ctl_wr && wdata_i[CTL_ABORT_BIT];
    assign soft_rst  = cfg_q.srst;

    assign fifo_pop  = !fifo_empty && ready_i;
    assign din_drop  = din_wr && fifo_full && !ready_i;
    assign din_push  = din_wr && !din_drop && (!pack_mode || din_half_q);
    assign din_word  = form_word(din_hi_q, bus_word, pack_mode, mode32);
    assign key_drop  = key_wr && key_valid_q && !key_ready_i;
    assign key_ld    = key_wr && !key_drop && (!pack_mode || key_half_q);
    assign key_word  = form_word(key_hi_q, bus_word, pack_mode, mode32);

    lw_sha_word_fifo #(
        .WORD_W     (WORD_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_din_fifo (
        .clk_i   (clk_i),
        .rst_ni  (resetn_i),
        .flush_i (abort_req || soft_rst),
        .push_i  (din_push),
        .data_i  (din_word),
        .pop_i   (fifo_pop),
        .data_o  (data_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    always_comb begin
        state_d     = state_q;
        cfg_d       = cfg_q;
        ie_d        = ie_q;
        hash_d      = hash_q;
        start_d     = 1'b0;
        last_d      = 1'b0;
        abort_d     = 1'b0;
        avl_set     = 1'b0;
        avl_clr     = 1'b0;
        din_half_d  = din_half_q;
        din_hi_d    = din_hi_q;
        key_half_d  = key_half_q;
        key_hi_d    = key_hi_q;
        key_d       = key_q;
        key_valid_d = key_valid_q && !key_ready_i;

        case (state_q)
            ST_IDLE:  if (ctl_wr && wdata_i[CTL_INIT_BIT]) state_d = ST_ARM;
            ST_ARM: begin
                if (core_ready_i) begin
                    start_d = 1'b1;
                    avl_clr = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN:   if (ctl_wr && wdata_i[CTL_LAST_BIT]) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (fifo_empty && !din_half_q && !key_half_q) begin
                    last_d  = 1'b1;
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (done_i) begin
                    hash_d  = hash_i;
                    avl_set = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default:  state_d = ST_IDLE;
        endcase

        // Packers: first write of a pair parks the high half.
        if (din_wr && !din_drop && pack_mode) begin
            din_half_d = !din_half_q;
            if (!din_half_q) din_hi_d = bus_word[31:0];
        end
        if (key_wr && !key_drop && pack_mode) begin
            key_half_d = !key_half_q;
            if (!key_half_q) key_hi_d = bus_word[31:0];
        end
        if (key_ld) begin
            key_d       = key_word;
            key_valid_d = 1'b1;
        end

        if (abort_req) begin
            state_d    = ST_IDLE;
            start_d    = 1'b0;
            last_d     = 1'b0;
            abort_d    = 1'b1;
            avl_set    = 1'b0;
            avl_clr    = 1'b0;
            hash_d     = hash_q;
            din_half_d = 1'b0;
            key_half_d = 1'b0;
        end

        if (cfg_wr) begin
            cfg_d.opcode     = wdata_i[3:0];
            cfg_d.hmacnewkey = wdata_i[CFG_NEWKEY_BIT];
            cfg_d.srst       = wdata_i[CFG_SRST_BIT];
`ifdef SHA_DIN_BYTE_SWAP_EN
            cfg_d.bswap      = wdata_i[CFG_BSWAP_BIT];
`endif
        end
        if (ie_wr) ie_d = ie_t'(wdata_i[STS_W-1:0]);

        // Sticky status: a set event beats a write-1-to-clear in the same cycle.
        derr_d = (din_drop || key_drop) ? 1'b1 :
                 (sts_wr && wdata_i[STS_DERR_BIT]) ? 1'b0 : derr_q;
        ovf_d  = din_drop ? 1'b1 :
                 (sts_wr && wdata_i[STS_OVF_BIT]) ? 1'b0 : ovf_q;
        avl_d  = avl_set ? 1'b1 :
                 (avl_clr || (sts_wr && wdata_i[STS_AVL_BIT])) ? 1'b0 : avl_q;

        if (soft_rst) begin
            state_d     = ST_IDLE;
            cfg_d       = '0;
            ie_d        = IE_RST;
            hash_d      = '0;
            start_d     = 1'b0;
            last_d      = 1'b0;
            abort_d     = 1'b0;
            avl_d       = 1'b0;
            derr_d      = 1'b0;
            ovf_d       = 1'b0;
            din_half_d  = 1'b0;
            din_hi_d    = '0;
            key_half_d  = 1'b0;
            key_hi_d    = '0;
            key_d       = '0;
            key_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q     <= ST_IDLE;
            cfg_q       <= '0;
            ie_q        <= IE_RST;
            hash_q      <= '0;
            start_q     <= 1'b0;
            last_q      <= 1'b0;
            abort_q     <= 1'b0;
            avl_q       <= 1'b0;
            derr_q      <= 1'b0;
            ovf_q       <= 1'b0;
            din_half_q  <= 1'b0;
            din_hi_q    <= '0;
            key_half_q  <= 1'b0;
            key_hi_q    <= '0;
            key_q       <= '0;
            key_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cfg_q       <= cfg_d;
            ie_q        <= ie_d;
            hash_q      <= hash_d;
            start_q     <= start_d;
            last_q      <= last_d;
            abort_q     <= abort_d;
            avl_q       <= avl_d;
            derr_q      <= derr_d;
            ovf_q       <= ovf_d;
            din_half_q  <= din_half_d;
            din_hi_q    <= din_hi_d;
            key_half_q  <= key_half_d;
            key_hi_q    <= key_hi_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
        end
    end

    always_comb begin
        sts_c      = '0;
        sts_c.avl  = avl_q;
        sts_c.rdyd = !fifo_full;
        sts_c.rdyk = key_ready_i && !key_valid_q;
        sts_c.derr = derr_q;
        sts_c.busy = (state_q != ST_IDLE);
        sts_c.fid  = fault_inj_det_i;
        sts_c.ovf  = ovf_q;
    end

    assign hash_idx = raddr_i[5:BYTE_SH];

    always_comb begin
        rdata_o      = '0;
        read_valid_o = 1'b0;
        if (rd_i) begin
            read_valid_o = 1'b1;
            case (raddr_i)
                ADDR_ID:   rdata_o = BUS_W'(ID_VAL);
                ADDR_CFG:  rdata_o = BUS_W'(cfg_to_reg(cfg_q));
                ADDR_STS:  rdata_o = BUS_W'(sts_c);
                ADDR_IE:   rdata_o = BUS_W'(ie_q);
                ADDR_FLVL: rdata_o = BUS_W'(fifo_level);
                ADDR_CTL, ADDR_DIN, ADDR_KEY: rdata_o = '0;
                default: begin
                    if (raddr_i >= ADDR_HASH_LO && raddr_i <= ADDR_HASH_HI) begin
                        if (32'(hash_idx) < HASH_CHUNKS) rdata_o = hash_q[hash_idx];
                    end else begin
                        read_valid_o = 1'b0;
                    end
                end
            endcase
        end
    end

    assign wr_ack_o     = wr_i;
    assign slv_error_o  = din_drop || key_drop;
    assign irq_o        = |(STS_W'(sts_c) & STS_W'(ie_q));
    assign valid_o      = !fifo_empty;
    assign key_o        = key_q;
    assign key_valid_o  = key_valid_q;
    assign start_o      = start_q;
    assign last_o       = last_q;
    assign abort_o      = abort_q;
    assign opcode_o     = cfg_q.opcode;
    assign new_key_o    = cfg_q.hmacnewkey;
    assign dma_wr_req_o = !fifo_full;
    assign dma_rd_req_o = avl_q;
    assign core_reset_o = !cfg_q.srst;

endmodule

// File: tb/tb_lw_sha_fifo_interface_ctrl.sv
// Directed self-checking bench for lw_sha_fifo_interface_ctrl (default parameters).
module tb_lw_sha_fifo_interface_ctrl;

    logic         clk_i = 1'b0;
    logic         resetn_i;
    logic         wr_i, rd_i;
    logic [11:0]  waddr_i, raddr_i;
    logic [31:0]  wdata_i, rdata_o;
    logic         wr_ack_o, read_valid_o, slv_error_o, irq_o;
    logic [63:0]  data_o, key_o;
    logic         valid_o, ready_i, key_valid_o, key_ready_i;
    logic         start_o, last_o, abort_o, new_key_o;
    logic [3:0]   opcode_o;
    logic         core_ready_i, done_i, fault_inj_det_i;
    logic [511:0] hash_i;
    logic         dma_wr_req_o, dma_rd_req_o, core_reset_o;

    int n_vec = 0;
    int n_err = 0;

    lw_sha_fifo_interface_ctrl dut (
        .clk_i(clk_i), .resetn_i(resetn_i),
        .wr_i(wr_i), .waddr_i(waddr_i), .wdata_i(wdata_i), .wr_ack_o(wr_ack_o),
        .rd_i(rd_i), .raddr_i(raddr_i), .rdata_o(rdata_o), .read_valid_o(read_valid_o),
        .slv_error_o(slv_error_o), .irq_o(irq_o),
        .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
        .key_o(key_o), .key_valid_o(key_valid_o), .key_ready_i(key_ready_i),
        .start_o(start_o), .last_o(last_o), .abort_o(abort_o),
        .opcode_o(opcode_o), .new_key_o(new_key_o),
        .core_ready_i(core_ready_i), .done_i(done_i), .fault_inj_det_i(fault_inj_det_i),
        .hash_i(hash_i), .dma_wr_req_o(dma_wr_req_o), .dma_rd_req_o(dma_rd_req_o),
        .core_reset_o(core_reset_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic bus_wr(input logic [11:0] a, input logic [31:0] d, output logic err);
        wr_i    = 1'b1;
        waddr_i = a;
        wdata_i = d;
        #1;
        err = slv_error_o;
        @(posedge clk_i);
        #1;
        wr_i = 1'b0;
    endtask

    task automatic bus_rd(input logic [11:0] a, output logic [31:0] d, output logic v);
        rd_i    = 1'b1;
        raddr_i = a;
        #1;
        d = rdata_o;
        v = read_valid_o;
        rd_i = 1'b0;
    endtask

    logic [31:0] rd;
    logic        rv, e, e_any;
    logic [63:0] exp_swap;

    initial begin
        resetn_i = 1'b0; wr_i = 1'b0; rd_i = 1'b0; waddr_i = '0; raddr_i = '0; wdata_i = '0;
        ready_i = 1'b0; key_ready_i = 1'b0; core_ready_i = 1'b0; done_i = 1'b0;
        fault_inj_det_i = 1'b0; hash_i = '0;
        repeat (3) tick();
        resetn_i = 1'b1;
        tick();

        // Reset state
        chk("rst_valid", valid_o, 0);
        chk("rst_data", data_o, 0);
        chk("rst_cmds", {start_o, last_o, abort_o, key_valid_o}, 0);
        chk("rst_core_reset", core_reset_o, 1);
        bus_rd(12'h040, rd, rv); chk("rst_ie", rd, 32'h2);
        bus_rd(12'h030, rd, rv); chk("rst_sts", rd, 32'h2);
        bus_rd(12'h000, rd, rv); chk("id", {rv, rd}, {1'b1, 32'h0});
        bus_rd(12'h060, rd, rv); chk("unmapped", {rv, rd}, 0);

        // Packing of two bus writes into one 64-bit word
        bus_wr(12'h010, 32'h4, e);
        chk("opcode", opcode_o, 4'h4);
        bus_wr(12'h140, 32'h11223344, e);
        chk("pack_half_valid", valid_o, 0);
        bus_wr(12'h140, 32'h55667788, e);
        chk("pack_valid", valid_o, 1);
        chk("pack_data", data_o, 64'h1122334455667788);
        bus_rd(12'h050, rd, rv); chk("pack_flvl", rd, 1);
        ready_i = 1'b1; tick(); ready_i = 1'b0;
        chk("pack_popped", valid_o, 0);

        // Overflow: fifth word with core stalled
        e_any = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus_wr(12'h140, 32'(32'hA0000000 + i), e); e_any |= e;
            bus_wr(12'h140, 32'(32'hB0000000 + i), e); e_any |= e;
        end
        chk("fill_no_err", e_any, 0);
        chk("full_dma_wr", dma_wr_req_o, 0);
        bus_wr(12'h140, 32'hC0000000, e);
        chk("ovf_err_hi", e, 1);
        bus_wr(12'h140, 32'hD0000000, e);
        chk("ovf_err_lo", e, 1);
        bus_rd(12'h030, rd, rv); chk("ovf_sts", rd, 32'h48);
        bus_rd(12'h050, rd, rv); chk("ovf_flvl", rd, 4);
        chk("ovf_head", data_o, 64'hA0000000B0000000);
        bus_wr(12'h030, 32'h48, e);
        bus_rd(12'h030, rd, rv); chk("w1c_sts", rd, 32'h0);
        ready_i = 1'b1; repeat (4) tick(); ready_i = 1'b0;
        chk("drained", valid_o, 0);

        // Command flow: init, start, last held until drained
        bus_wr(12'h020, 32'h1, e);
        chk("arm_no_start", start_o, 0);
        bus_rd(12'h030, rd, rv); chk("arm_sts_busy", rd, 32'h12);
        core_ready_i = 1'b1;
        tick(); chk("start_pulse", start_o, 1);
        tick(); chk("start_end", start_o, 0);
        core_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus_wr(12'h140, 32'(32'h10 + i), e);
            bus_wr(12'h140, 32'(32'h20 + i), e);
        end
        bus_wr(12'h020, 32'h2, e);
        for (int i = 0; i < 3; i++) begin
            tick(); chk("drain_hold_last", last_o, 0);
        end
        bus_rd(12'h050, rd, rv); chk("drain_flvl", rd, 3);
        ready_i = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick(); chk($sformatf("last_cyc%0d", k), last_o, (k == 4) ? 1 : 0);
        end
        ready_i = 1'b0;

        // Digest capture on done
        bus_wr(12'h040, 32'h1, e);
        chk("irq_before_done", irq_o, 0);
        hash_i[63:0]   = 64'hDEADBEEF_CAFEF00D;
        hash_i[127:64] = 64'h01234567_89ABCDEF;
        done_i = 1'b1; tick(); done_i = 1'b0;
        hash_i = '0;
        bus_rd(12'h030, rd, rv); chk("done_sts", rd, 32'h3);
        chk("done_irq", irq_o, 1);
        chk("done_dma_rd", dma_rd_req_o, 1);
        bus_rd(12'h100, rd, rv); chk("hash_w0_lo", {rv, rd}, {1'b1, 32'hCAFEF00D});
        bus_rd(12'h104, rd, rv); chk("hash_w0_hi", rd, 32'hDEADBEEF);
        bus_rd(12'h108, rd, rv); chk("hash_w1_lo", rd, 32'h89ABCDEF);
        bus_wr(12'h030, 32'h1, e);
        chk("avl_w1c_irq", irq_o, 0);

        // Abort from DRAIN with two words queued
        bus_wr(12'h020, 32'h1, e);
        core_ready_i = 1'b1; tick(); core_ready_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus_wr(12'h140, 32'(32'h30 + i), e);
            bus_wr(12'h140, 32'(32'h40 + i), e);
        end
        bus_wr(12'h020, 32'h2, e);
        bus_rd(12'h050, rd, rv); chk("pre_abort_flvl", rd, 2);
        bus_wr(12'h020, 32'h4, e);
        chk("abort_pulse", abort_o, 1);
        bus_rd(12'h050, rd, rv); chk("abort_flvl", rd, 0);
        chk("abort_valid", valid_o, 0);
        tick(); chk("abort_end", abort_o, 0);
        hash_i = {512{1'b1}};
        done_i = 1'b1; tick(); done_i = 1'b0;
        hash_i = '0;
        bus_rd(12'h030, rd, rv); chk("abort_sts", rd, 32'h2);
        bus_rd(12'h100, rd, rv); chk("abort_hash_kept", rd, 32'hCAFEF00D);

        // 32-bit mode, optional byte swap
        bus_wr(12'h010, 32'h100, e);
        bus_wr(12'h140, 32'h01020304, e);
        chk("m32_valid", valid_o, 1);
`ifdef SHA_DIN_BYTE_SWAP_EN
        exp_swap = 64'h04030201;
        bus_rd(12'h010, rd, rv); chk("cfg_bswap", rd, 32'h100);
`else
        exp_swap = 64'h01020304;
        bus_rd(12'h010, rd, rv); chk("cfg_bswap", rd, 32'h0);
`endif
        chk("m32_data", data_o, exp_swap);

        // Soft reset
        bus_wr(12'h010, 32'h80000004, e);
        chk("srst_core_reset", core_reset_o, 0);
        tick();
        chk("srst_done", core_reset_o, 1);
        bus_rd(12'h050, rd, rv); chk("srst_flvl", rd, 0);
        bus_rd(12'h040, rd, rv); chk("srst_ie", rd, 32'h2);
        bus_rd(12'h010, rd, rv); chk("srst_cfg", rd, 32'h0);

        // Key path
        bus_wr(12'h010, 32'h4, e);
        key_ready_i = 1'b1;
        bus_wr(12'h150, 32'hAAAA0000, e);
        bus_wr(12'h150, 32'hBBBB0000, e);
        chk("key_load_err", e, 0);
        key_ready_i = 1'b0;
        chk("key_valid", key_valid_o, 1);
        chk("key_data", key_o, 64'hAAAA0000BBBB0000);
        bus_wr(12'h150, 32'h12345678, e);
        chk("key_busy_err", e, 1);
        chk("key_hold", {key_valid_o, key_o}, {1'b1, 64'hAAAA0000BBBB0000});
        bus_rd(12'h030, rd, rv); chk("key_sts", rd, 32'h0A);
        key_ready_i = 1'b1;
        tick();
        chk("key_consumed", key_valid_o, 0);
        bus_rd(12'h030, rd, rv); chk("key_sts_rdyk", rd, 32'h0E);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
